alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Hardwired control sequencer for the phase-1/phase-2 datapath.
- Generates all bus, register and ALU strobes for one instruction: fetch, then a register-register or register-unary ALU operation.
- Covers the full ALU op set, including the MUL/DIV HI/LO write-back.
- Parametrised in register-file size and field widths, with a memory-ready wait/timeout and fault reporting; replaces hand-sequenced bench control.

Parameters:
- NUM_REGS, 16, number of general registers; width of the Rin/Rout one-hot vectors.
- SEL_W, 4, register-select field width in IR.
- OPC_W, 5, opcode field width in IR.
- IR_W, 32, instruction width.
- MEM_TIMEOUT, 15, maximum T1 wait cycles for Mem_ready before a fault.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  synchronous active-high reset.
- Run  in  1  start or continue execution; sampled in IDLE and DONE.
- Mem_ready  in  1  memory data valid during T1.
- IR  in  IR_W  instruction register contents from the datapath.
- Rin  out  NUM_REGS  one-hot register load enables.
- Rout  out  NUM_REGS  one-hot register bus drives.
- PCout, PCin, MARin, MDRin, MDRout, IRin, IncPC, Read, Yin, Zin, Zhighout, Zlowout, HIin, LOin  out  1 each  datapath strobes.
- Alu_op  out  13  one-hot ALU select. Bit order: ADD0 SUB1 SHR2 SHRA3 SHL4 ROR5 ROL6 AND7 OR8 MUL9 DIV10 NEG11 NOT12.
- Busy  out  1  high in every state except IDLE and FAULT.
- Done  out  1  one-cycle pulse on completion.
- Fault  out  2  00 none, 01 illegal opcode or register, 10 memory timeout.

Behaviour:
- Reset: Clear=1 at a rising edge forces state IDLE, the wait counter to 0 and Fault to 00. All outputs are 0 while in IDLE. Clear takes priority mid-instruction; no strobe remains asserted in the cycle after the reset edge.
- Outputs are a Moore decode of the state register plus the latched decode. Each strobe is asserted for exactly the cycle spent in its state. No two bus drivers are ever asserted in the same cycle.
- IR fields: opcode = IR[IR_W-1 -: OPC_W]; Ra = next SEL_W bits; Rb = next SEL_W bits; Rc = next SEL_W bits.
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
- State sequence and strobes:
  - IDLE: Run=1 -> T0.
  - T0: PCout, MARin, IncPC, Zin -> T1.
  - T1: Zlowout, PCin, Read, MDRin. Stay in T1 while Mem_ready=0, incrementing the wait counter. Mem_ready=1 -> T2. Counter reaches MEM_TIMEOUT with Mem_ready still 0 -> FAULT with Fault=10.
  - Re-entry into T1 after a wait: PCin is asserted only in the first T1 cycle, so the PC is incremented exactly once. Read and MDRin stay high for the whole wait.
  - T2: MDRout, IRin -> T3.
  - T3: decode IR and latch opcode, Ra, Rb, Rc internally.
    - Illegal opcode, or any used select >= NUM_REGS -> FAULT with Fault=01, and no strobe is asserted in T3.
    - Binary op: Rout[Rb], Yin -> T4.
    - NEG/NOT: Rout[Rb], Alu_op, Zin -> T5 (no Y cycle).
  - T4: Rout[Rc], Alu_op, Zin -> T5.
  - T5:
    - Normal op: Zlowout, Rin[Ra] -> DONE.
    - MUL/DIV: Zlowout, LOin -> T6.
  - T6 (MUL/DIV only): Zhighout, HIin -> DONE. Ra is not written.
  - DONE: Done=1. Run=1 -> T0 (back-to-back fetch); Run=0 -> IDLE.
  - FAULT: all strobes 0, Fault held until Clear. Run is ignored.
- Latency from Run sampled to Done with Mem_ready tied high:
  - Binary op: 7 cycles (T0..T5, DONE).
  - MUL/DIV: 8 cycles.
  - NEG/NOT: 6 cycles.
  - Each wait cycle adds 1.
- The wait counter clears on entry to T0.

Test Plan:
- Reset with Run=1 and Mem_ready=1, IR=AND R1,R2,R3 (opcode 00101, Ra=1, Rb=2, Rc=3) -> Rout[2]+Yin in T3; Rout[3]+Alu_op=0x0080+Zin in T4; Zlowout+Rin[1] in T5; Done in the 7th cycle after Run is sampled.
- MUL R0,R4,R5 -> T5 Zlowout+LOin, T6 Zhighout+HIin, Rin=0 throughout, Done at cycle 8.
- NOT R6,R7 -> T3 Rout[7]+Alu_op=0x1000+Zin, Yin never asserted, Rin[6] in T5, Done at cycle 6.
- Mem_ready low for 3 cycles -> T1 held 4 cycles, PCin high in the first only, Read high for all 4, Done delayed by 3.
- Mem_ready stuck at 0 -> Fault=10 after 15 wait cycles, Busy=0, all strobes 0, cleared only by Clear.
- Opcode 11111 -> Fault=01 after T3. Separately, Clear asserted in T4 -> all outputs 0 on the next cycle and state IDLE.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Control bundle between the hardwired sequencer and the phase-1/phase-2 datapath.
interface alu_op_sequencer_if #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IR_W     = 32
);

  // Inputs to the sequencer
  logic                Run;
  logic                Mem_ready;
  logic [IR_W-1:0]     IR;

  // Register-file strobes
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;

  // Datapath strobes
  logic                PCout;
  logic                PCin;
  logic                MARin;
  logic                MDRin;
  logic                MDRout;
  logic                IRin;
  logic                IncPC;
  logic                Read;
  logic                Yin;
  logic                Zin;
  logic                Zhighout;
  logic                Zlowout;
  logic                HIin;
  logic                LOin;
  logic [12:0]         Alu_op;

  // Status
  logic                Busy;
  logic                Done;
  logic [1:0]          Fault;

  // Sequencer side
  modport master (
    input  Run, Mem_ready, IR,
    output Rin, Rout,
    output PCout, PCin, MARin, MDRin, MDRout, IRin, IncPC, Read,
    output Yin, Zin, Zhighout, Zlowout, HIin, LOin, Alu_op,
    output Busy, Done, Fault
  );

  // Datapath / environment side
  modport slave (
    output Run, Mem_ready, IR,
    input  Rin, Rout,
    input  PCout, PCin, MARin, MDRin, MDRout, IRin, IncPC, Read,
    input  Yin, Zin, Zhighout, Zlowout, HIin, LOin, Alu_op,
    input  Busy, Done, Fault
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Hardwired instruction sequencer: fetch, decode and one ALU operation per Run.
module alu_op_sequencer #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned IR_W        = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                Clear,
  alu_op_sequencer_if.master  bus
);

  localparam int unsigned ALU_W  = 13;
  localparam int unsigned CNT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned RA_MSB = IR_W - OPC_W - 1;
  localparam int unsigned RB_MSB = RA_MSB - SEL_W;
  localparam int unsigned RC_MSB = RB_MSB - SEL_W;

  // Alu_op bit positions
  localparam int unsigned A_ADD  = 0;
  localparam int unsigned A_SUB  = 1;
  localparam int unsigned A_SHR  = 2;
  localparam int unsigned A_SHRA = 3;
  localparam int unsigned A_SHL  = 4;
  localparam int unsigned A_ROR  = 5;
  localparam int unsigned A_ROL  = 6;
  localparam int unsigned A_AND  = 7;
  localparam int unsigned A_OR   = 8;
  localparam int unsigned A_MUL  = 9;
  localparam int unsigned A_DIV  = 10;
  localparam int unsigned A_NEG  = 11;
  localparam int unsigned A_NOT  = 12;

  // Opcode encodings
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(5'b00111);
  localparam logic [OPC_W-1:0] OP_SHRA = OPC_W'(5'b01000);
  localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(5'b01001);
  localparam logic [OPC_W-1:0] OP_ROR  = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OP_ROL  = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(5'b01111);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(5'b10000);
  localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(5'b10001);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(5'b10010);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE,
    S_FAULT
  } state_t;

  // Map an opcode to its one-hot ALU select; zero means illegal opcode.
  function automatic logic [ALU_W-1:0] alu_decode(input logic [OPC_W-1:0] opc);
    logic [ALU_W-1:0] sel;
    sel = '0;
    case (opc)
      OP_ADD:  sel[A_ADD]  = 1'b1;
      OP_SUB:  sel[A_SUB]  = 1'b1;
      OP_AND:  sel[A_AND]  = 1'b1;
      OP_OR:   sel[A_OR]   = 1'b1;
      OP_SHR:  sel[A_SHR]  = 1'b1;
      OP_SHRA: sel[A_SHRA] = 1'b1;
      OP_SHL:  sel[A_SHL]  = 1'b1;
      OP_ROR:  sel[A_ROR]  = 1'b1;
      OP_ROL:  sel[A_ROL]  = 1'b1;
      OP_MUL:  sel[A_MUL]  = 1'b1;
      OP_DIV:  sel[A_DIV]  = 1'b1;
      OP_NEG:  sel[A_NEG]  = 1'b1;
      OP_NOT:  sel[A_NOT]  = 1'b1;
      default: sel = '0;
    endcase
    return sel;
  endfunction

  // A register select is usable only if it names an existing register.
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return 32'(sel) < NUM_REGS;
  endfunction

  // One-hot register enable for a select field.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [SEL_W-1:0] sel);
    return NUM_REGS'(1) << sel;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [1:0]          fault_q, fault_d;
  logic [ALU_W-1:0]    alu_q;
  logic [SEL_W-1:0]    ra_q;
  logic [SEL_W-1:0]    rc_q;
  logic                muldiv_q;

  logic [OPC_W-1:0]    ir_opc;
  logic [SEL_W-1:0]    ir_ra;
  logic [SEL_W-1:0]    ir_rb;
  logic [SEL_W-1:0]    ir_rc;
  logic [ALU_W-1:0]    ir_alu;
  logic                ir_unary;
  logic                ir_muldiv;
  logic                ir_legal;
  logic                unused_ir;

  logic [NUM_REGS-1:0] rin_c;
  logic [NUM_REGS-1:0] rout_c;
  logic                pcout_c, pcin_c, marin_c, mdrin_c, mdrout_c, irin_c, incpc_c, read_c;
  logic                yin_c, zin_c, zhighout_c, zlowout_c, hiin_c, loin_c;
  logic [ALU_W-1:0]    alu_op_c;
  logic                busy_c, done_c;

  // Instruction field extraction and decode of the live IR (valid from T3 on).
  assign ir_opc    = bus.IR[IR_W-1 -: OPC_W];
  assign ir_ra     = bus.IR[RA_MSB -: SEL_W];
  assign ir_rb     = bus.IR[RB_MSB -: SEL_W];
  assign ir_rc     = bus.IR[RC_MSB -: SEL_W];
  assign ir_alu    = alu_decode(ir_opc);
  assign ir_unary  = ir_alu[A_NEG] | ir_alu[A_NOT];
  assign ir_muldiv = ir_alu[A_MUL] | ir_alu[A_DIV];
  assign ir_legal  = (|ir_alu)
                   & sel_valid(ir_rb)
                   & (ir_unary  | sel_valid(ir_rc))
                   & (ir_muldiv | sel_valid(ir_ra));
  assign unused_ir = ^bus.IR;

  // State, wait counter, fault code and latched decode.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      fault_q  <= 2'b00;
      alu_q    <= '0;
      ra_q     <= '0;
      rc_q     <= '0;
      muldiv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      if (state_q == S_T3) begin
        alu_q    <= ir_alu;
        ra_q     <= ir_ra;
        rc_q     <= ir_rc;
        muldiv_q <= ir_muldiv;
      end
    end
  end

  // Next-state and per-state strobe decode.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    fault_d    = fault_q;
    rin_c      = '0;
    rout_c     = '0;
    pcout_c    = 1'b0;
    pcin_c     = 1'b0;
    marin_c    = 1'b0;
    mdrin_c    = 1'b0;
    mdrout_c   = 1'b0;
    irin_c     = 1'b0;
    incpc_c    = 1'b0;
    read_c     = 1'b0;
    yin_c      = 1'b0;
    zin_c      = 1'b0;
    zhighout_c = 1'b0;
    zlowout_c  = 1'b0;
    hiin_c     = 1'b0;
    loin_c     = 1'b0;
    alu_op_c   = '0;
    done_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Run) begin
          state_d = S_T0;
          wait_d  = '0;
        end
      end
      S_T0: begin
        pcout_c = 1'b1;
        marin_c = 1'b1;
        incpc_c = 1'b1;
        zin_c   = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        // PC load only on the first T1 cycle so a memory wait increments it once.
        zlowout_c = 1'b1;
        pcin_c    = (wait_q == '0);
        read_c    = 1'b1;
        mdrin_c   = 1'b1;
        if (bus.Mem_ready) begin
          state_d = S_T2;
        end else if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_T2: begin
        mdrout_c = 1'b1;
        irin_c   = 1'b1;
        state_d  = S_T3;
      end
      S_T3: begin
        if (!ir_legal) begin
          state_d = S_FAULT;
          fault_d = 2'b01;
        end else if (ir_unary) begin
          rout_c   = reg_onehot(ir_rb);
          alu_op_c = ir_alu;
          zin_c    = 1'b1;
          state_d  = S_T5;
        end else begin
          rout_c  = reg_onehot(ir_rb);
          yin_c   = 1'b1;
          state_d = S_T4;
        end
      end
      S_T4: begin
        rout_c   = reg_onehot(rc_q);
        alu_op_c = alu_q;
        zin_c    = 1'b1;
        state_d  = S_T5;
      end
      S_T5: begin
        zlowout_c = 1'b1;
        if (muldiv_q) begin
          loin_c  = 1'b1;
          state_d = S_T6;
        end else begin
          rin_c   = reg_onehot(ra_q);
          state_d = S_DONE;
        end
      end
      S_T6: begin
        zhighout_c = 1'b1;
        hiin_c     = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_c = 1'b1;
        if (bus.Run) begin
          state_d = S_T0;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Busy covers every active state; IDLE and FAULT are the resting states.
  assign busy_c = (state_q != S_IDLE) && (state_q != S_FAULT);

  // Drive the control bundle.
  assign bus.Rin      = rin_c;
  assign bus.Rout     = rout_c;
  assign bus.PCout    = pcout_c;
  assign bus.PCin     = pcin_c;
  assign bus.MARin    = marin_c;
  assign bus.MDRin    = mdrin_c;
  assign bus.MDRout   = mdrout_c;
  assign bus.IRin     = irin_c;
  assign bus.IncPC    = incpc_c;
  assign bus.Read     = read_c;
  assign bus.Yin      = yin_c;
  assign bus.Zin      = zin_c;
  assign bus.Zhighout = zhighout_c;
  assign bus.Zlowout  = zlowout_c;
  assign bus.HIin     = hiin_c;
  assign bus.LOin     = loin_c;
  assign bus.Alu_op   = alu_op_c;
  assign bus.Busy     = busy_c;
  assign bus.Done     = done_c;
  assign bus.Fault    = fault_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: per-cycle strobe trace versus an instruction-level model.
module tb_alu_op_sequencer;

  localparam int unsigned NR          = 16;
  localparam int unsigned IRW         = 32;
  localparam int unsigned MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.NUM_REGS(NR), .IR_W(IRW)) bus ();

  alu_op_sequencer #(
    .NUM_REGS(NR), .SEL_W(4), .OPC_W(5), .IR_W(IRW), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .Clock(clk),
    .Clear(clr),
    .bus  (bus)
  );

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pcout, pcin, marin, mdrin, mdrout, irin, incpc, read;
    logic        yin, zin, zhighout, zlowout, hiin, loin;
    logic [12:0] alu;
    logic        busy, done;
    logic [1:0]  fault;
  } obs_t;

  typedef struct packed {
    obs_t        o;
    logic        mr;
    logic        run;
    logic [31:0] ir;
  } step_t;

  step_t sched[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Opcode for each Alu_op bit position
  logic [4:0] opc_tab [13] = '{5'h03, 5'h04, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B,
                               5'h05, 5'h06, 5'h0F, 5'h10, 5'h11, 5'h12};

  function automatic int alu_index(input logic [4:0] opc);
    for (int k = 0; k < 13; k++) if (opc_tab[k] == opc) return k;
    return -1;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.rin = bus.Rin;        o.rout = bus.Rout;
    o.pcout = bus.PCout;    o.pcin = bus.PCin;     o.marin = bus.MARin;
    o.mdrin = bus.MDRin;    o.mdrout = bus.MDRout; o.irin = bus.IRin;
    o.incpc = bus.IncPC;    o.read = bus.Read;     o.yin = bus.Yin;
    o.zin = bus.Zin;        o.zhighout = bus.Zhighout; o.zlowout = bus.Zlowout;
    o.hiin = bus.HIin;      o.loin = bus.LOin;     o.alu = bus.Alu_op;
    o.busy = bus.Busy;      o.done = bus.Done;     o.fault = bus.Fault;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input int ra, input int rb, input int rc);
    return {opc, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
  endfunction

  task automatic add_step(input obs_t o, input logic mr, input logic run, input logic [31:0] ir);
    step_t s;
    s.o = o; s.mr = mr; s.run = run; s.ir = ir;
    sched.push_back(s);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting at its first fetch cycle.
  task automatic model_instr(input logic [31:0] ir, input int waits, input bit timeout, input bit chain);
    obs_t       o;
    logic [4:0] opc;
    int         ra, rb, rc, k;
    opc = ir[31:27];
    ra  = int'(ir[26:23]);
    rb  = int'(ir[22:19]);
    rc  = int'(ir[18:15]);
    // fetch: address out
    o = '0; o.busy = 1'b1; o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.zin = 1'b1;
    add_step(o, rbit(), rbit(), ir);
    // fetch: memory read, possibly stalled
    if (timeout) begin
      for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
        o = '0; o.busy = 1'b1; o.zlowout = 1'b1; o.read = 1'b1; o.mdrin = 1'b1; o.pcin = (i == 0);
        add_step(o, 1'b0, rbit(), ir);
      end
      o = '0; o.fault = 2'b10;
      for (int i = 0; i < 3; i++) add_step(o, rbit(), rbit(), ir);
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      o = '0; o.busy = 1'b1; o.zlowout = 1'b1; o.read = 1'b1; o.mdrin = 1'b1; o.pcin = (i == 0);
      add_step(o, (i == waits), rbit(), ir);
    end
    // fetch: instruction load
    o = '0; o.busy = 1'b1; o.mdrout = 1'b1; o.irin = 1'b1;
    add_step(o, rbit(), rbit(), ir);
    // decode / operand cycles
    k = alu_index(opc);
    if (k < 0) begin
      o = '0; o.busy = 1'b1;
      add_step(o, rbit(), rbit(), ir);
      o = '0; o.fault = 2'b01;
      for (int i = 0; i < 3; i++) add_step(o, rbit(), rbit(), ir);
      return;
    end
    o = '0; o.busy = 1'b1; o.rout[rb] = 1'b1;
    if (k >= 11) begin
      o.alu[k] = 1'b1; o.zin = 1'b1;
      add_step(o, rbit(), rbit(), ir);
    end else begin
      o.yin = 1'b1;
      add_step(o, rbit(), rbit(), ir);
      o = '0; o.busy = 1'b1; o.rout[rc] = 1'b1; o.alu[k] = 1'b1; o.zin = 1'b1;
      add_step(o, rbit(), rbit(), ir);
    end
    // write-back
    o = '0; o.busy = 1'b1; o.zlowout = 1'b1;
    if (k == 9 || k == 10) begin
      o.loin = 1'b1;
      add_step(o, rbit(), rbit(), ir);
      o = '0; o.busy = 1'b1; o.zhighout = 1'b1; o.hiin = 1'b1;
      add_step(o, rbit(), rbit(), ir);
    end else begin
      o.rin[ra] = 1'b1;
      add_step(o, rbit(), rbit(), ir);
    end
    // completion
    o = '0; o.busy = 1'b1; o.done = 1'b1;
    add_step(o, rbit(), chain, ir);
    if (!chain) begin
      o = '0;
      add_step(o, rbit(), 1'b0, ir);
    end
  endtask

  // Launch from IDLE and compare up to n cycles of the schedule.
  task automatic run_sched(input string name, input int n);
    step_t s;
    obs_t  got;
    int    i;
    i = 0;
    if (sched.size() > 0) begin
      bus.IR  = sched[0].ir;
      bus.Run = 1'b1;
    end
    while (i < n && sched.size() > 0) begin
      s = sched.pop_front();
      @(posedge clk); #1;
      got = sample();
      n_tests++;
      if (got !== s.o) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", name, i, got, s.o);
      end
      bus.Mem_ready = s.mr;
      bus.Run       = s.run;
      bus.IR        = s.ir;
      i++;
    end
    sched.delete();
  endtask

  // Clear with Run held high, then confirm a quiet IDLE.
  task automatic do_clear(input string name);
    obs_t got;
    clr     = 1'b1;
    bus.Run = 1'b1;
    @(posedge clk); #1;
    got = sample();
    n_tests++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL %s clear: got %h expected 0", name, got);
    end
    clr     = 1'b0;
    bus.Run = 1'b0;
    @(posedge clk); #1;
    got = sample();
    n_tests++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL %s idle after clear: got %h expected 0", name, got);
    end
  endtask

  task automatic test_reset();
    obs_t got;
    clr = 1'b1; bus.Run = 1'b1; bus.Mem_ready = 1'b1;
    bus.IR = mk_ir(5'b00101, 1, 2, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = sample();
      n_tests++;
      if (got !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h expected 0", i, got);
      end
    end
    clr = 1'b0; bus.Run = 1'b0;
  endtask

  task automatic test_binary();
    model_instr(mk_ir(5'b00101, 1, 2, 3), 0, 1'b0, 1'b0);
    run_sched("and_r1_r2_r3", 1000);
    model_instr(mk_ir(5'b00011, 15, 0, 15), 0, 1'b0, 1'b0);
    run_sched("add_r15_r0_r15", 1000);
  endtask

  task automatic test_muldiv();
    model_instr(mk_ir(5'b01111, 0, 4, 5), 0, 1'b0, 1'b0);
    run_sched("mul_r0_r4_r5", 1000);
    model_instr(mk_ir(5'b10000, 9, 10, 11), 1, 1'b0, 1'b0);
    run_sched("div_r9_r10_r11", 1000);
  endtask

  task automatic test_unary();
    model_instr(mk_ir(5'b10010, 6, 7, 0), 0, 1'b0, 1'b0);
    run_sched("not_r6_r7", 1000);
    model_instr(mk_ir(5'b10001, 3, 12, 9), 2, 1'b0, 1'b0);
    run_sched("neg_r3_r12", 1000);
  endtask

  task automatic test_mem_wait();
    model_instr(mk_ir(5'b00101, 1, 2, 3), 3, 1'b0, 1'b0);
    run_sched("wait3", 1000);
    model_instr(mk_ir(5'b00110, 4, 5, 6), int'(MEM_TIMEOUT) - 1, 1'b0, 1'b0);
    run_sched("wait_max", 1000);
  endtask

  task automatic test_timeout();
    model_instr(mk_ir(5'b00100, 2, 3, 4), 0, 1'b1, 1'b0);
    run_sched("timeout", 1000);
    do_clear("timeout");
  endtask

  task automatic test_illegal();
    logic [4:0] opc;
    model_instr(mk_ir(5'b11111, 1, 2, 3), 0, 1'b0, 1'b0);
    run_sched("illegal_11111", 1000);
    do_clear("illegal_11111");
    for (int j = 0; j < 4; j++) begin
      do opc = 5'($urandom); while (alu_index(opc) >= 0);
      model_instr(mk_ir(opc, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                  $urandom_range(0, 2), 1'b0, 1'b0);
      run_sched("illegal_rand", 1000);
      do_clear("illegal_rand");
    end
  endtask

  task automatic test_clear_mid();
    model_instr(mk_ir(5'b00101, 1, 2, 3), 0, 1'b0, 1'b0);
    run_sched("clear_mid", 5);
    do_clear("clear_mid");
  endtask

  task automatic test_back_to_back();
    int n;
    for (int p = 0; p < 3; p++) begin
      n = 10;
      for (int j = 0; j < n; j++) begin
        model_instr(mk_ir(opc_tab[$urandom_range(0, 12)], $urandom_range(0, 15),
                          $urandom_range(0, 15), $urandom_range(0, 15)),
                    $urandom_range(0, 3), 1'b0, (j != n - 1));
      end
      run_sched("back_to_back", 100000);
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.Run = 1'b0;
    bus.Mem_ready = 1'b0;
    bus.IR = '0;
    test_reset();
    test_binary();
    test_muldiv();
    test_unary();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_clear_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
